datapath: RTL and testbench
===========================

DATAPATH -- requirements
Module: datapath

Interface
REQ-001 Clock  in  1  sole clock; all storage updates on rising edge.
REQ-002 Clear  in  1  asynchronous, active-low reset; 0 clears every register immediately.
REQ-003 Mdatain  in  32  memory read data, MDR source when Read=1.
REQ-004 encIn  in  32  one-hot bus-source select; bit map in REQ-014.
REQ-005 Read  in  1  MDR input mux select: 1 selects Mdatain, 0 selects busMuxOut.
REQ-006 R0in..R15in, HIin, LOin, ZHIin, ZLOin, PCin, INPORTin, CSIGNin, MDRin, Yin  in  1 each  per-register load enables, active-high.
REQ-007 R0..R15, HI, LO, ZHI, ZLO, PC, MDR, INPORT, CSIGN, RY  out  32 each  current register contents; RY is the Y register.
REQ-008 NOT  in  1  ALU control: 1 selects bitwise complement.
REQ-009 busMuxOut  out  32  current internal bus value, combinational.
REQ-010 Port order: Mdatain, encIn, Clock, Clear, Read, the enables as listed in REQ-006, the outputs as listed in REQ-007, NOT, busMuxOut.

Function
REQ-011 Each register SHALL load its input on a rising Clock edge when its enable=1 and hold otherwise.
REQ-012 R0..R15, HI, LO, PC, INPORT, CSIGN, Y SHALL load from busMuxOut; R0 is an ordinary register, not hardwired zero.
REQ-013 MDR SHALL load (Read ? Mdatain : busMuxOut) when MDRin=1.
REQ-014 encIn bit map: bits 0-15 R0-R15, 16 HI, 17 LO, 18 ZHI, 19 ZLO, 20 PC, 21 MDR, 22 INPORT, 23 CSIGN; bits 24-31 unused.
REQ-015 encIn SHALL be encoded to a 5-bit select; when several bits are set, the lowest set index wins.
REQ-016 busMuxOut SHALL be 32'h0 when encIn has no valid bit set, including when only bits 24-31 are set.
REQ-017 busMuxOut SHALL follow encIn and register contents combinationally, with zero cycle latency.
REQ-018 ALU result C is 64 bits: NOT=1 gives C = {32'h0, ~busMuxOut}; NOT=0 gives C = {32'h0, busMuxOut}.
REQ-019 ZHI SHALL load C[63:32] when ZHIin=1; ZLO SHALL load C[31:0] when ZLOin=1; ZHIin and ZLOin are independent.
REQ-020 Simultaneous enables SHALL all load the same edge's bus value.
REQ-021 Reading and writing the same register in one cycle SHALL store the pre-edge bus value.
REQ-022 The block SHALL have no state machine; sequencing belongs to the controller.

Reset
REQ-023 Clear=0 SHALL asynchronously force all 25 registers (R0-R15, HI, LO, ZHI, ZLO, PC, MDR, INPORT, CSIGN, Y) to 32'h0.
REQ-024 While Clear=0, enables SHALL be ignored; loading resumes at the first rising edge after Clear returns to 1.
REQ-025 Reset asserted mid-sequence SHALL discard all prior loads; busMuxOut then reflects the zeroed registers.

Structure
REQ-026 A shared package SHALL hold the bus-source index constants (REQ-014) and the data width parameter (32).
REQ-027 One sub-module, reg32 (32-bit register with enable and async active-low clear), SHALL be instantiated for every register.
REQ-028 The encoder, bus mux, MDR input mux and ALU SHALL be coded inline in datapath.

Verification
REQ-029 Mdatain=0x12, Read=1, MDRin=1, one edge -> MDR=0x00000012.
REQ-030 encIn=1<<21 with MDR=0x12 -> busMuxOut=0x12; then R0in=1 for one edge -> R0=0x12; then Yin=1 for one edge -> RY=0x12.
REQ-031 encIn=1<<21 with MDR=0x12, NOT=1, ZLOin=1, ZHIin=1, one edge -> ZLO=0xFFFFFFED, ZHI=0x0.
REQ-032 encIn=0x00000000 or 0x80000000 -> busMuxOut=0; encIn=(1<<3)|(1<<21) -> busMuxOut=R3.
REQ-033 Load distinct values into R0-R15, HI, LO, PC, INPORT, CSIGN, then read each back one-hot -> each value is returned on busMuxOut.
REQ-034 Drive Clear=0 between edges after loads -> all outputs are 0 immediately; an enable held high during Clear=0 causes no load.

Source files
------------

// File: rtl/datapath_pkg.sv
// datapath_pkg -- shared constants for the register-file datapath.
//   DATA_W      : register / bus width
//   NUM_SRC     : number of bus sources selectable through encIn
//   SRC_*       : encIn bit index (and encoded select value) of each bus source
//   SEL_W       : width of the encoded bus select
package datapath_pkg;

  localparam int DATA_W  = 32;
  localparam int NUM_GPR = 16;
  localparam int NUM_SRC = 24;
  localparam int SEL_W   = 5;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [SEL_W-1:0]  sel_t;

  // Bus-source bit map of encIn; bits 24..31 select nothing.
  localparam int SRC_R0     = 0;
  localparam int SRC_HI     = 16;
  localparam int SRC_LO     = 17;
  localparam int SRC_ZHI    = 18;
  localparam int SRC_ZLO    = 19;
  localparam int SRC_PC     = 20;
  localparam int SRC_MDR    = 21;
  localparam int SRC_INPORT = 22;
  localparam int SRC_CSIGN  = 23;

endpackage

// File: rtl/reg32.sv
// reg32 -- DATA_W-bit register with load enable and asynchronous active-low clear.
//   gclk   : clock, loads on rising edge
//   grst_n : async clear, forces q to zero while low
//   en     : load enable, active high
//   d      : load data
//   q      : register contents
module reg32
  import datapath_pkg::*;
#(
  parameter int W = DATA_W
) (
  input  logic         gclk,
  input  logic         grst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n)  q <= '0;
    else if (en)  q <= d;
  end

endmodule

// File: rtl/datapath.sv
// datapath -- register file, one-hot bus, MDR input mux and NOT/pass ALU.
//   Mdatain            : memory read data, MDR source when Read=1
//   encIn              : one-hot bus-source select (lowest set bit wins)
//   Clock / Clear      : clock / async active-low clear of every register
//   Read               : MDR input select (1 = Mdatain, 0 = bus)
//   R0in..Yin          : per-register load enables
//   R0..R15,HI,..,RY   : register contents (RY is the Y register)
//   NOT                : ALU complement select
//   busMuxOut          : combinational internal bus
// Purely a datapath: no sequencing state lives here.
module datapath
  import datapath_pkg::*;
(
  input  logic [DATA_W-1:0] Mdatain,
  input  logic [DATA_W-1:0] encIn,
  input  logic              Clock,
  input  logic              Clear,
  input  logic              Read,
  input  logic              R0in,
  input  logic              R1in,
  input  logic              R2in,
  input  logic              R3in,
  input  logic              R4in,
  input  logic              R5in,
  input  logic              R6in,
  input  logic              R7in,
  input  logic              R8in,
  input  logic              R9in,
  input  logic              R10in,
  input  logic              R11in,
  input  logic              R12in,
  input  logic              R13in,
  input  logic              R14in,
  input  logic              R15in,
  input  logic              HIin,
  input  logic              LOin,
  input  logic              ZHIin,
  input  logic              ZLOin,
  input  logic              PCin,
  input  logic              INPORTin,
  input  logic              CSIGNin,
  input  logic              MDRin,
  input  logic              Yin,
  output logic [DATA_W-1:0] R0,
  output logic [DATA_W-1:0] R1,
  output logic [DATA_W-1:0] R2,
  output logic [DATA_W-1:0] R3,
  output logic [DATA_W-1:0] R4,
  output logic [DATA_W-1:0] R5,
  output logic [DATA_W-1:0] R6,
  output logic [DATA_W-1:0] R7,
  output logic [DATA_W-1:0] R8,
  output logic [DATA_W-1:0] R9,
  output logic [DATA_W-1:0] R10,
  output logic [DATA_W-1:0] R11,
  output logic [DATA_W-1:0] R12,
  output logic [DATA_W-1:0] R13,
  output logic [DATA_W-1:0] R14,
  output logic [DATA_W-1:0] R15,
  output logic [DATA_W-1:0] HI,
  output logic [DATA_W-1:0] LO,
  output logic [DATA_W-1:0] ZHI,
  output logic [DATA_W-1:0] ZLO,
  output logic [DATA_W-1:0] PC,
  output logic [DATA_W-1:0] MDR,
  output logic [DATA_W-1:0] INPORT,
  output logic [DATA_W-1:0] CSIGN,
  output logic [DATA_W-1:0] RY,
  input  logic              NOT,
  output logic [DATA_W-1:0] busMuxOut
);

  // ---------------------------------------------------------------- GPRs
  logic [NUM_GPR-1:0]             gpr_en;
  logic [NUM_GPR-1:0][DATA_W-1:0] gpr_q;

  assign gpr_en = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                   R7in,  R6in,  R5in,  R4in,  R3in,  R2in,  R1in, R0in};

  for (genvar g = 0; g < NUM_GPR; g++) begin : g_gpr
    reg32 u_gpr (
      .gclk   (Clock),
      .grst_n (Clear),
      .en     (gpr_en[g]),
      .d      (busMuxOut),
      .q      (gpr_q[g])
    );
  end

  assign R0  = gpr_q[0];
  assign R1  = gpr_q[1];
  assign R2  = gpr_q[2];
  assign R3  = gpr_q[3];
  assign R4  = gpr_q[4];
  assign R5  = gpr_q[5];
  assign R6  = gpr_q[6];
  assign R7  = gpr_q[7];
  assign R8  = gpr_q[8];
  assign R9  = gpr_q[9];
  assign R10 = gpr_q[10];
  assign R11 = gpr_q[11];
  assign R12 = gpr_q[12];
  assign R13 = gpr_q[13];
  assign R14 = gpr_q[14];
  assign R15 = gpr_q[15];

  // ------------------------------------------------------ MDR mux and ALU
  word_t               mdr_d;
  logic [2*DATA_W-1:0] alu_c;

  assign mdr_d = Read ? Mdatain : busMuxOut;
  // Only the low half carries data; the high half is a defined zero so
  // ZHI has a well-defined source for future wide operations.
  assign alu_c = {{DATA_W{1'b0}}, (NOT ? ~busMuxOut : busMuxOut)};

  // ---------------------------------------------------- special registers
  reg32 u_hi     (.gclk(Clock), .grst_n(Clear), .en(HIin),     .d(busMuxOut),             .q(HI));
  reg32 u_lo     (.gclk(Clock), .grst_n(Clear), .en(LOin),     .d(busMuxOut),             .q(LO));
  reg32 u_zhi    (.gclk(Clock), .grst_n(Clear), .en(ZHIin),    .d(alu_c[2*DATA_W-1:DATA_W]), .q(ZHI));
  reg32 u_zlo    (.gclk(Clock), .grst_n(Clear), .en(ZLOin),    .d(alu_c[DATA_W-1:0]),     .q(ZLO));
  reg32 u_pc     (.gclk(Clock), .grst_n(Clear), .en(PCin),     .d(busMuxOut),             .q(PC));
  reg32 u_mdr    (.gclk(Clock), .grst_n(Clear), .en(MDRin),    .d(mdr_d),                 .q(MDR));
  reg32 u_inport (.gclk(Clock), .grst_n(Clear), .en(INPORTin), .d(busMuxOut),             .q(INPORT));
  reg32 u_csign  (.gclk(Clock), .grst_n(Clear), .en(CSIGNin),  .d(busMuxOut),             .q(CSIGN));
  reg32 u_y      (.gclk(Clock), .grst_n(Clear), .en(Yin),      .d(busMuxOut),             .q(RY));

  // ---------------------------------------------------------- bus sources
  logic [NUM_SRC-1:0][DATA_W-1:0] src;

  always_comb begin
    src = '0;
    for (int i = 0; i < NUM_GPR; i++) src[SRC_R0+i] = gpr_q[i];
    src[SRC_HI]     = HI;
    src[SRC_LO]     = LO;
    src[SRC_ZHI]    = ZHI;
    src[SRC_ZLO]    = ZLO;
    src[SRC_PC]     = PC;
    src[SRC_MDR]    = MDR;
    src[SRC_INPORT] = INPORT;
    src[SRC_CSIGN]  = CSIGN;
  end

  // -------------------------------------------------- encoder and bus mux
  // Scan downward so the lowest set bit is the last (winning) assignment.
  sel_t sel;
  logic sel_vld;

  always_comb begin
    sel     = '0;
    sel_vld = 1'b0;
    for (int i = NUM_SRC-1; i >= 0; i--) begin
      if (encIn[i]) begin
        sel     = SEL_W'(i);
        sel_vld = 1'b1;
      end
    end
  end

  // encIn[31:24] map to no source; a word with only those bits set drives zero.
  logic unused_enc_hi;
  assign unused_enc_hi = ^encIn[DATA_W-1:NUM_SRC];

  assign busMuxOut = sel_vld ? src[sel] : '0;

endmodule

// File: tb/tb_datapath.sv
module tb_datapath;

  logic        Clock = 1'b0;
  logic        Clear;
  logic        Read, NOT;
  logic [31:0] Mdatain, encIn;
  logic [24:0] en;
  logic [24:0][31:0] act;
  logic [31:0] bus;

  // Index map shared by model, enables and outputs: 0-15 R0-R15, 16 HI,
  // 17 LO, 18 ZHI, 19 ZLO, 20 PC, 21 MDR, 22 INPORT, 23 CSIGN, 24 Y.
  localparam int IMDR = 21, IZHI = 18, IZLO = 19, IY = 24;

  datapath dut (
    .Mdatain(Mdatain), .encIn(encIn), .Clock(Clock), .Clear(Clear), .Read(Read),
    .R0in(en[0]), .R1in(en[1]), .R2in(en[2]), .R3in(en[3]), .R4in(en[4]), .R5in(en[5]),
    .R6in(en[6]), .R7in(en[7]), .R8in(en[8]), .R9in(en[9]), .R10in(en[10]), .R11in(en[11]),
    .R12in(en[12]), .R13in(en[13]), .R14in(en[14]), .R15in(en[15]),
    .HIin(en[16]), .LOin(en[17]), .ZHIin(en[18]), .ZLOin(en[19]), .PCin(en[20]),
    .INPORTin(en[22]), .CSIGNin(en[23]), .MDRin(en[21]), .Yin(en[24]),
    .R0(act[0]), .R1(act[1]), .R2(act[2]), .R3(act[3]), .R4(act[4]), .R5(act[5]),
    .R6(act[6]), .R7(act[7]), .R8(act[8]), .R9(act[9]), .R10(act[10]), .R11(act[11]),
    .R12(act[12]), .R13(act[13]), .R14(act[14]), .R15(act[15]),
    .HI(act[16]), .LO(act[17]), .ZHI(act[18]), .ZLO(act[19]), .PC(act[20]),
    .MDR(act[21]), .INPORT(act[22]), .CSIGN(act[23]), .RY(act[24]),
    .NOT(NOT), .busMuxOut(bus)
  );

  always #5 Clock = ~Clock;

  typedef struct packed {
    logic [31:0]       bus;
    logic [24:0][31:0] r;
  } exp_t;

  exp_t sb[$];
  logic [24:0][31:0] m;   // reference register contents
  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] bus_of(input logic [31:0] sel, input logic [24:0][31:0] st);
    for (int i = 0; i < 24; i++) if (sel[i]) return st[i];
    return 32'h0;
  endfunction

  // Record what the DUT must show during this cycle, then advance the model
  // across the coming rising edge.
  task automatic step();
    logic [31:0] b;
    logic [63:0] c;
    logic [24:0][31:0] nxt;
    if (!Clear) m = '0;
    b = bus_of(encIn, m);
    sb.push_back({b, m});
    if (Clear) begin
      c   = {32'h0, (NOT ? ~b : b)};
      nxt = m;
      for (int i = 0; i < 25; i++) begin
        if (en[i]) begin
          if (i == IMDR)      nxt[i] = Read ? Mdatain : b;
          else if (i == IZHI) nxt[i] = c[63:32];
          else if (i == IZLO) nxt[i] = c[31:0];
          else                nxt[i] = b;
        end
      end
      m = nxt;
    end
    @(posedge Clock);
    #1;
  endtask

  task automatic idle();
    en = '0; Read = 1'b0; NOT = 1'b0; encIn = '0; Mdatain = '0;
  endtask

  task automatic load_mdr(input logic [31:0] v);
    idle(); Mdatain = v; Read = 1'b1; en[IMDR] = 1'b1; step();
  endtask

  task automatic copy_mdr_to(input int idx);
    idle(); encIn = 32'h1 << IMDR; en[idx] = 1'b1; step();
  endtask

  // Monitor: every cycle the DUT's outputs are sampled mid-cycle and
  // compared with the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge Clock);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (bus !== e.bus) begin
          errors++;
          $display("FAIL busMuxOut t=%0t encIn=%h got=%h exp=%h", $time, encIn, bus, e.bus);
        end
        for (int i = 0; i < 25; i++) begin
          checks++;
          if (act[i] !== e.r[i]) begin
            errors++;
            $display("FAIL reg[%0d] t=%0t got=%h exp=%h", i, $time, act[i], e.r[i]);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end

  int idx_list[21] = '{0,1,2,3,4,5,6,7,8,9,10,11,12,13,14,15,16,17,20,22,23};

  initial begin
    m = '0;
    idle();
    Clear = 1'b0;
    @(posedge Clock); #1;
    step();                                   // reset state
    Clear = 1'b1;
    step();

    // MDR from memory, bus readout, copies into R0 and Y
    load_mdr(32'h12);
    idle(); encIn = 32'h1 << IMDR; step();
    copy_mdr_to(0);
    copy_mdr_to(IY);
    idle(); step();

    // complement through the ALU into ZLO/ZHI
    idle(); encIn = 32'h1 << IMDR; NOT = 1'b1; en[IZHI] = 1'b1; en[IZLO] = 1'b1; step();
    idle(); encIn = 32'h1 << IZLO; step();

    // empty / unused-bit selects and priority
    idle(); encIn = 32'h0; step();
    idle(); encIn = 32'h8000_0000; step();
    idle(); encIn = 32'hFF00_0000; step();
    load_mdr(32'hABCD_0003);
    copy_mdr_to(3);
    idle(); encIn = (32'h1 << 3) | (32'h1 << IMDR); step();

    // distinct value in every bus-loadable register, then read each back
    foreach (idx_list[k]) begin
      load_mdr(32'h5A00_0000 | (idx_list[k] * 32'h0101) | 32'h1);
      copy_mdr_to(idx_list[k]);
    end
    foreach (idx_list[k]) begin
      idle(); encIn = 32'h1 << idx_list[k]; step();
    end

    // same register as source and destination keeps the pre-edge bus value
    idle(); encIn = 32'h1 << 7; en[7] = 1'b1; en[8] = 1'b1; step();
    idle(); encIn = 32'h1 << 8; step();

    // async clear between edges, enables held high while clear is low
    idle(); encIn = 32'h1 << 5; en[5] = 1'b1; en[9] = 1'b1; en[IY] = 1'b1;
    Clear = 1'b0; step();
    step();
    Clear = 1'b1; idle(); encIn = 32'h1 << 5; step();

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      idle();
      Mdatain = $urandom();
      Read    = 1'(($urandom() >> 3) & 1);
      NOT     = 1'(($urandom() >> 5) & 1);
      case ($urandom_range(0, 5))
        0:       encIn = 32'h1 << $urandom_range(0, 31);
        1:       encIn = 32'h1 << $urandom_range(0, 23);
        2:       encIn = 32'h1 << $urandom_range(0, 23);
        3:       encIn = (32'h1 << $urandom_range(0, 23)) | (32'h1 << $urandom_range(0, 31));
        4:       encIn = 32'h0;
        default: encIn = $urandom();
      endcase
      for (int b = 0; b < 25; b++) en[b] = ($urandom_range(0, 4) == 0);
      Clear = ($urandom_range(0, 49) != 0);
      step();
    end
    Clear = 1'b1;
    idle(); step();

    for (int w = 0; w < 10 && sb.size() > 0; w++) @(negedge Clock);
    @(negedge Clock);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d exp=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
